// File: rtl/hp_mul_seq_ctrl.sv
// hp_mul_seq_ctrl: sequential binary16 multiplier, radix-4 Booth, valid/ready.
// Optional HP_MUL_RNE_EN selects round-to-nearest-even; default truncates.
module hp_mul_seq_ctrl #(
  parameter int BIAS       = 15,
  parameter bit SAT_ON_OVF = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic [1:0]  out_exc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BOOTH,
    NORM,
    DONE
  } state_t;

  localparam logic [6:0] BIAS7 = 7'(BIAS);

  state_t state;
  logic [2:0] cnt;

  logic       sgn_a;
  logic       sgn_b;
  logic [4:0] exp_a;
  logic [4:0] exp_b;
  logic [9:0] man_a;
  logic [9:0] man_b;

  logic signed [13:0] acc;
  logic [12:0]        mq;

  logic accept;

  assign in_ready = (state == IDLE) |
                    ((state == DONE) & out_ready);
  assign accept = in_valid & in_ready;

  // Booth step: recode mq[2:0], add, then shift {acc,mq} right by 2
  logic signed [13:0] m_ext;
  logic signed [13:0] pp;
  logic signed [13:0] acc_sum;
  logic signed [13:0] acc_nxt;
  logic [12:0]        mq_nxt;

  assign m_ext = {4'b0001, man_a};

  always_comb begin
    pp = '0;
    unique case (mq[2:0])
      3'b001,
      3'b010:  pp = m_ext;
      3'b011:  pp = m_ext <<< 1;
      3'b100:  pp = -(m_ext <<< 1);
      3'b101,
      3'b110:  pp = -m_ext;
      default: pp = '0;
    endcase
  end

  assign acc_sum = acc + pp;
  assign acc_nxt = {{2{acc_sum[13]}}, acc_sum[13:2]};
  assign mq_nxt  = {acc_sum[1:0], mq[12:2]};

  logic [21:0] prod;
  logic        hi;
  logic [9:0]  man_t;
  logic [9:0]  man_f;
  logic [6:0]  e_base;
  logic [6:0]  e_fin;

  assign prod   = {acc[9:0], mq[12:1]};
  assign hi     = prod[21];
  assign man_t  = hi ? prod[20:11] : prod[19:10];
  assign e_base = {2'b00, exp_a} + {2'b00, exp_b}
                - BIAS7 + {6'd0, hi};

`ifdef HP_MUL_RNE_EN
  logic        guard;
  logic        sticky;
  logic        rnd_up;
  logic [10:0] man_r;

  assign guard  = hi ? prod[10] : prod[9];
  assign sticky = hi ? |prod[9:0] : |prod[8:0];
  assign rnd_up = guard & (sticky | man_t[0]);
  assign man_r  = {1'b0, man_t} + {10'd0, rnd_up};
  assign man_f  = man_r[9:0];
  assign e_fin  = e_base + {6'd0, man_r[10]};
`else
  assign man_f = man_t;
  assign e_fin = e_base;
`endif

  logic unused_bits;
  assign unused_bits = ^{acc[13:10], mq[0], prod[9:0]};

  logic s;
  logic a_inf;
  logic b_inf;
  logic a_nan;
  logic b_nan;
  logic a_zero;
  logic b_zero;
  logic e_ovf;
  logic e_unf;

  assign s      = sgn_a ^ sgn_b;
  assign a_inf  = (exp_a == 5'h1F);
  assign b_inf  = (exp_b == 5'h1F);
  assign a_nan  = a_inf & (|man_a);
  assign b_nan  = b_inf & (|man_b);
  assign a_zero = (exp_a == 5'h00);
  assign b_zero = (exp_b == 5'h00);
  assign e_ovf  = $signed(e_fin) >= 7'sd31;
  assign e_unf  = $signed(e_fin) <= 7'sd0;

  logic [15:0] res_p;
  logic [1:0]  res_exc;

  always_comb begin
    res_p   = {s, e_fin[4:0], man_f};
    res_exc = 2'b00;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      res_p   = 16'h7E00;
      res_exc = 2'b11;
    end else if (a_inf | b_inf) begin
      res_p   = {s, 5'h1F, 10'h000};
      res_exc = 2'b01;
    end else if (a_zero | b_zero) begin
      res_p   = {s, 15'h0000};
      res_exc = 2'b00;
    end else if (e_ovf) begin
      res_p   = SAT_ON_OVF ? {s, 5'h1E, 10'h3FF}
                           : {s, 5'h1F, 10'h000};
      res_exc = 2'b01;
    end else if (e_unf) begin
      res_p   = {s, 15'h0000};
      res_exc = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_exc   <= '0;
      sgn_a     <= 1'b0;
      sgn_b     <= 1'b0;
      exp_a     <= '0;
      exp_b     <= '0;
      man_a     <= '0;
      man_b     <= '0;
      acc       <= '0;
      mq        <= '0;
    end else begin
      if (accept) begin
        sgn_a <= in_a[15];
        sgn_b <= in_b[15];
        exp_a <= in_a[14:10];
        exp_b <= in_b[14:10];
        man_a <= in_a[9:0];
        man_b <= in_b[9:0];
        acc   <= '0;
        mq    <= {1'b0, 1'b1, in_b[9:0], 1'b0};
        cnt   <= '0;
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state <= BOOTH;
            busy  <= 1'b1;
          end
        end
        BOOTH: begin
          acc <= acc_nxt;
          mq  <= mq_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            state <= NORM;
          end
        end
        NORM: begin
          out_p     <= res_p;
          out_exc   <= res_exc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              state <= BOOTH;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
